loss: RTL

- Output-layer error unit at the far end of a node's forward/backward protocol.
- Consumes the forward activations from the output-layer nodes and a target vector.
- Returns per-lane error (target − activation) on the backward interface that feeds the nodes' input_backward port.
- Optionally reports mean squared error per epoch for training monitoring.

---
 rtl/loss_if.sv | 52 +++++
 rtl/loss.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/loss_if.sv
// Forward/target/backward/loss handshake bundle for the output-layer error unit.
// The master side is whoever produces activations and targets and consumes the
// error and loss results; the slave side is the loss unit itself.
interface loss_if #(
    parameter int N = 1
);
    logic              input_forward_valid;
    logic [N*8-1:0]    input_forward_data;
    logic              input_forward_ready;

    logic              target_valid;
    logic [N*8-1:0]    target_data;
    logic              target_ready;

    logic              output_backward_valid;
    logic [N*16-1:0]   output_backward_data;
    logic              output_backward_ready;

    logic              loss_valid;
    logic [31:0]       loss_data;
    logic              loss_ready;

    modport master (
        output input_forward_valid,
        output input_forward_data,
        input  input_forward_ready,
        output target_valid,
        output target_data,
        input  target_ready,
        input  output_backward_valid,
        input  output_backward_data,
        output output_backward_ready,
        input  loss_valid,
        input  loss_data,
        output loss_ready
    );

    modport slave (
        input  input_forward_valid,
        input  input_forward_data,
        output input_forward_ready,
        input  target_valid,
        input  target_data,
        output target_ready,
        output output_backward_valid,
        output output_backward_data,
        input  output_backward_ready,
        output loss_valid,
        output loss_data,
        input  loss_ready
    );
endinterface

// File: rtl/loss.sv
// Output-layer error unit.
// Captures an activation vector and a target vector (independently, in any
// order), then walks the lanes one per cycle computing err = target - activation
// as a sign-extended Q8.8 value and presents the whole error vector on the
// backward interface.
//
// Optional feature macro: LOSS_EN
//   defined   : squared errors are accumulated over 2^E samples and the mean
//               (accumulator >> E) is reported once per epoch on the loss port.
//   undefined : no accumulator, sample counter or LOSS state; loss_valid and
//               loss_data are tied to zero and loss_ready is ignored.
// The port list is the same in both builds.
module loss #(
    parameter int N = 1,
    parameter int E = 2
) (
    input  logic  clock,
    input  logic  reset,
    loss_if.slave bus
);

    // Lane counter needs at least one bit even for a single lane.
    localparam int            LW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);

`ifdef LOSS_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        BWD  = 2'd2,
        LOSS = 2'd3
    } state_t;

    // Sample counter width; E = 0 would mean a one-sample epoch.
    localparam int            SW       = (E > 0) ? E : 1;
    localparam logic [SW-1:0] SMP_LAST = SW'((1 << E) - 1);
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        BWD  = 2'd2
    } state_t;

    // The epoch length only matters when the loss report is built.
    localparam int unused_e_p = E;
`endif

    state_t            state_r;
    logic              have_fwd_r;
    logic              have_tgt_r;
    logic [N*8-1:0]    act_r;
    logic [N*8-1:0]    tgt_r;
    logic [LW-1:0]     lane_r;
    logic              bwd_valid_r;
    logic [N*16-1:0]   bwd_data_r;

    logic              fwd_ready_s;
    logic              tgt_ready_s;
    logic              fwd_take_s;
    logic              tgt_take_s;
    logic [7:0]        act_lane_s;
    logic [7:0]        tgt_lane_s;
    logic signed [8:0] err_s;
    logic [15:0]       err16_s;

`ifdef LOSS_EN
    logic [SW-1:0]      smp_r;
    logic [31:0]        acc_r;
    logic               loss_valid_r;
    logic [31:0]        loss_data_r;
    logic signed [17:0] err_wide_s;
    logic signed [17:0] sq_s;
`else
    logic               unused_s;
`endif

    // Both capture slots are open only while idle and not yet filled.
    assign fwd_ready_s = (state_r == IDLE) && !have_fwd_r;
    assign tgt_ready_s = (state_r == IDLE) && !have_tgt_r;
    assign fwd_take_s  = fwd_ready_s && bus.input_forward_valid;
    assign tgt_take_s  = tgt_ready_s && bus.target_valid;

    // Select the current lane and form its signed error (range -255..+255).
    always_comb begin
        act_lane_s = 8'd0;
        tgt_lane_s = 8'd0;
        for (int i = 0; i < N; i++) begin
            act_lane_s = act_lane_s | (act_r[i*8 +: 8] & {8{lane_r == LW'(i)}});
            tgt_lane_s = tgt_lane_s | (tgt_r[i*8 +: 8] & {8{lane_r == LW'(i)}});
        end
        err_s   = $signed({1'b0, tgt_lane_s}) - $signed({1'b0, act_lane_s});
        err16_s = {{7{err_s[8]}}, err_s};
    end

`ifdef LOSS_EN
    // Square of the current lane error; at most 65025 so 18 signed bits suffice.
    always_comb begin
        err_wide_s = 18'(err_s);
        sq_s       = err_wide_s * err_wide_s;
    end
`endif

    // Control FSM with the capture slots, lane walk, backward and loss registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            have_fwd_r   <= 1'b0;
            have_tgt_r   <= 1'b0;
            act_r        <= '0;
            tgt_r        <= '0;
            lane_r       <= '0;
            bwd_valid_r  <= 1'b0;
            bwd_data_r   <= '0;
`ifdef LOSS_EN
            smp_r        <= '0;
            acc_r        <= 32'd0;
            loss_valid_r <= 1'b0;
            loss_data_r  <= 32'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (fwd_take_s) begin
                        have_fwd_r <= 1'b1;
                        act_r      <= bus.input_forward_data;
                    end
                    if (tgt_take_s) begin
                        have_tgt_r <= 1'b1;
                        tgt_r      <= bus.target_data;
                    end
                    // Leave as soon as both vectors are held, even if both
                    // arrived on this very edge.
                    if ((have_fwd_r || fwd_take_s) && (have_tgt_r || tgt_take_s)) begin
                        state_r <= ERR;
                        lane_r  <= '0;
                    end
                end

                ERR: begin
                    for (int i = 0; i < N; i++) begin
                        if (lane_r == LW'(i)) begin
                            bwd_data_r[i*16 +: 16] <= err16_s;
                        end
                    end
`ifdef LOSS_EN
                    acc_r <= acc_r + {14'd0, sq_s};
`endif
                    if (lane_r == LAST_LANE) begin
                        lane_r      <= '0;
                        bwd_valid_r <= 1'b1;
                        state_r     <= BWD;
                    end else begin
                        lane_r <= lane_r + LW'(1);
                    end
                end

                BWD: begin
                    if (bus.output_backward_ready) begin
                        bwd_valid_r <= 1'b0;
                        have_fwd_r  <= 1'b0;
                        have_tgt_r  <= 1'b0;
`ifdef LOSS_EN
                        // Last sample of the epoch: freeze the mean and report it.
                        if (smp_r == SMP_LAST) begin
                            smp_r        <= '0;
                            loss_data_r  <= acc_r >> E;
                            loss_valid_r <= 1'b1;
                            state_r      <= LOSS;
                        end else begin
                            smp_r   <= smp_r + SW'(1);
                            state_r <= IDLE;
                        end
`else
                        state_r <= IDLE;
`endif
                    end
                end

`ifdef LOSS_EN
                LOSS: begin
                    if (bus.loss_ready) begin
                        loss_valid_r <= 1'b0;
                        acc_r        <= 32'd0;
                        state_r      <= IDLE;
                    end
                end
`endif

                default: begin
                    state_r     <= IDLE;
                    lane_r      <= '0;
                    have_fwd_r  <= 1'b0;
                    have_tgt_r  <= 1'b0;
                    bwd_valid_r <= 1'b0;
`ifndef SYNTHESIS
                    $error("loss: illegal state %0d", state_r);
`endif
                end
            endcase
        end
    end

    assign bus.input_forward_ready   = fwd_ready_s;
    assign bus.target_ready          = tgt_ready_s;
    assign bus.output_backward_valid = bwd_valid_r;
    assign bus.output_backward_data  = bwd_data_r;

`ifdef LOSS_EN
    assign bus.loss_valid = loss_valid_r;
    assign bus.loss_data  = loss_data_r;
`else
    assign bus.loss_valid = 1'b0;
    assign bus.loss_data  = 32'd0;
    assign unused_s       = bus.loss_ready;
`endif

endmodule
